// File: rtl/clk_monitor.sv
// clk_monitor: health checker for an asynchronous, free-running clock.
// The monitored clock is synchronized into the clk domain. Each high and low
// phase is measured in clk cycles. The block reports every completed period,
// keeps sticky range/stuck errors and asserts lock once the clock is stable.
//
// Optional build macro: CLK_MON_DUTY_EN enables the duty-cycle check. When it
// is undefined, err_duty is tied low and no duty logic is built.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-high reset
//   mon_clk    in   monitored clock (asynchronous to clk)
//   clr_err    in   one-cycle pulse clearing the sticky errors
//   high_len   out  last captured high-phase length   [CNT_W]
//   low_len    out  last captured low-phase length    [CNT_W]
//   period     out  high_len + low_len of last period [CNT_W+1]
//   meas_valid out  one-cycle pulse when period updates
//   locked     out  clock stable for LOCK_CNT consecutive good periods
//   err_range  out  sticky: a phase was outside [MIN_HALF, MAX_HALF]
//   err_stuck  out  sticky: no edge seen for TIMEOUT cycles
//   err_duty   out  sticky: |high - low| exceeded DUTY_TOL
module clk_monitor #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned MIN_HALF = 4,
    parameter int unsigned MAX_HALF = 64,
    parameter int unsigned TIMEOUT  = 256,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned DUTY_TOL = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mon_clk,
    input  logic             clr_err,
    output logic [CNT_W-1:0] high_len,
    output logic [CNT_W-1:0] low_len,
    output logic [CNT_W:0]   period,
    output logic             meas_valid,
    output logic             locked,
    output logic             err_range,
    output logic             err_stuck,
    output logic             err_duty
);

    localparam int unsigned PER_W = CNT_W + 1;
    localparam int unsigned LCK_W = $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] MIN_C      = CNT_W'(MIN_HALF);
    localparam logic [CNT_W-1:0] MAX_C      = CNT_W'(MAX_HALF);
    localparam logic [LCK_W-1:0] LOCK_C     = LCK_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [LCK_W-1:0] LCK_ONE    = LCK_W'(1);

    // Elaboration-time parameter sanity checks.
    if ((TIMEOUT <= MAX_HALF) || (TIMEOUT > ((1 << CNT_W) - 1))) begin : g_bad_timeout
        $error("clk_monitor: TIMEOUT must satisfy MAX_HALF < TIMEOUT <= 2^CNT_W-1");
    end
    if (DUTY_TOL > ((1 << CNT_W) - 1)) begin : g_bad_duty_tol
        $error("clk_monitor: DUTY_TOL must fit in CNT_W bits");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             s3_q, s3_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] high_len_q, high_len_d;
    logic [CNT_W-1:0] low_len_q, low_len_d;
    logic [PER_W-1:0] period_q, period_d;
    logic             meas_valid_q, meas_valid_d;
    logic             high_ok_q, high_ok_d;
    logic [LCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic             locked_q, locked_d;
    logic             err_range_q, err_range_d;
    logic             err_stuck_q, err_stuck_d;

    logic rise_c;
    logic fall_c;
    logic edge_c;
    logic timeout_c;
    logic cnt_ok_c;
    logic duty_bad_c;
    logic range_set;
    logic stuck_set;
    logic duty_set;
    logic lock_clr;
    logic lock_inc;

    // Synchronizer plus history flop for edge detection.
    always_comb begin
        s1_d = mon_clk;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    assign rise_c    = s2_q & ~s3_q;
    assign fall_c    = ~s2_q & s3_q;
    assign edge_c    = rise_c | fall_c;
    assign timeout_c = (cnt_q == TIMEOUT_C);
    assign cnt_ok_c  = (cnt_q >= MIN_C) && (cnt_q <= MAX_C);

    // Phase counter: restarts at 1 on an edge so a capture equals the level's
    // length in clk cycles; saturates at the stuck threshold.
    always_comb begin
        cnt_d = cnt_q;
        if (edge_c) begin
            cnt_d = CNT_ONE;
        end else if (!timeout_c) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

`ifdef CLK_MON_DUTY_EN
    logic             err_duty_q, err_duty_d;
    logic [CNT_W-1:0] duty_diff_c;
    localparam logic [CNT_W-1:0] DUTY_C = CNT_W'(DUTY_TOL);

    // Duty compares the stored high phase against the low phase being captured.
    always_comb begin
        if (high_len_q >= cnt_q) begin
            duty_diff_c = high_len_q - cnt_q;
        end else begin
            duty_diff_c = cnt_q - high_len_q;
        end
        duty_bad_c = (duty_diff_c > DUTY_C);
    end

    always_comb begin
        err_duty_d = duty_set | (err_duty_q & ~clr_err);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_duty_q <= 1'b0;
        end else begin
            err_duty_q <= err_duty_d;
        end
    end

    assign err_duty = err_duty_q;
`else
    assign duty_bad_c = 1'b0;
    assign err_duty   = 1'b0;
`endif

    // Measurement FSM: next state, captures and error/lock events.
    always_comb begin
        state_d      = state_q;
        high_len_d   = high_len_q;
        low_len_d    = low_len_q;
        period_d     = period_q;
        meas_valid_d = 1'b0;
        high_ok_d    = high_ok_q;
        range_set    = 1'b0;
        stuck_set    = 1'b0;
        duty_set     = 1'b0;
        lock_clr     = 1'b0;
        lock_inc     = 1'b0;

        case (state_q)
            IDLE: begin
                if (rise_c) begin
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (timeout_c) begin
                    stuck_set = 1'b1;
                    lock_clr  = 1'b1;
                    state_d   = IDLE;
                end else if (fall_c) begin
                    high_len_d = cnt_q;
                    high_ok_d  = cnt_ok_c;
                    if (!cnt_ok_c) begin
                        range_set = 1'b1;
                        lock_clr  = 1'b1;
                    end
                    state_d = LOW;
                end
            end
            LOW: begin
                if (timeout_c) begin
                    stuck_set = 1'b1;
                    lock_clr  = 1'b1;
                    state_d   = IDLE;
                end else if (rise_c) begin
                    low_len_d    = cnt_q;
                    period_d     = PER_W'(high_len_q) + PER_W'(cnt_q);
                    meas_valid_d = 1'b1;
                    if (!cnt_ok_c) begin
                        range_set = 1'b1;
                        lock_clr  = 1'b1;
                    end
                    if (duty_bad_c) begin
                        duty_set = 1'b1;
                        lock_clr = 1'b1;
                    end
                    // Only a period with both phases good advances the lock.
                    if (cnt_ok_c && high_ok_q && !duty_bad_c) begin
                        lock_inc = 1'b1;
                    end
                    state_d = HIGH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Lock counter and sticky errors; a set in the same cycle as clr_err wins.
    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (lock_clr) begin
            lock_cnt_d = '0;
        end else if (lock_inc && (lock_cnt_q != LOCK_C)) begin
            lock_cnt_d = lock_cnt_q + LCK_ONE;
        end
        locked_d    = (lock_cnt_d == LOCK_C);
        err_range_d = range_set | (err_range_q & ~clr_err);
        err_stuck_d = stuck_set | (err_stuck_q & ~clr_err);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            cnt_q        <= '0;
            high_len_q   <= '0;
            low_len_q    <= '0;
            period_q     <= '0;
            meas_valid_q <= 1'b0;
            high_ok_q    <= 1'b0;
            lock_cnt_q   <= '0;
            locked_q     <= 1'b0;
            err_range_q  <= 1'b0;
            err_stuck_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            s3_q         <= s3_d;
            cnt_q        <= cnt_d;
            high_len_q   <= high_len_d;
            low_len_q    <= low_len_d;
            period_q     <= period_d;
            meas_valid_q <= meas_valid_d;
            high_ok_q    <= high_ok_d;
            lock_cnt_q   <= lock_cnt_d;
            locked_q     <= locked_d;
            err_range_q  <= err_range_d;
            err_stuck_q  <= err_stuck_d;
        end
    end

    assign high_len   = high_len_q;
    assign low_len    = low_len_q;
    assign period     = period_q;
    assign meas_valid = meas_valid_q;
    assign locked     = locked_q;
    assign err_range  = err_range_q;
    assign err_stuck  = err_stuck_q;

endmodule

// File: tb/tb_clk_monitor.sv
// tb_clk_monitor: directed bench for clk_monitor. The monitored clock is
// changed on the falling edge of clk so every phase length is an exact
// number of clk cycles and expected values are fixed integers.
module tb_clk_monitor;

    localparam int unsigned CNT_W = 16;

`ifdef CLK_MON_DUTY_EN
    localparam int DUTY_EXP = 1;
`else
    localparam int DUTY_EXP = 0;
`endif

    logic             clk;
    logic             reset;
    logic             mon_clk;
    logic             clr_err;
    logic [CNT_W-1:0] high_len;
    logic [CNT_W-1:0] low_len;
    logic [CNT_W:0]   period;
    logic             meas_valid;
    logic             locked;
    logic             err_range;
    logic             err_stuck;
    logic             err_duty;

    int errors = 0;
    int checks = 0;
    int mv_cnt = 0;
    int mv_snap = 0;
    logic mv_prev = 1'b0;

    clk_monitor dut (
        .clk        (clk),
        .reset      (reset),
        .mon_clk    (mon_clk),
        .clr_err    (clr_err),
        .high_len   (high_len),
        .low_len    (low_len),
        .period     (period),
        .meas_valid (meas_valid),
        .locked     (locked),
        .err_range  (err_range),
        .err_stuck  (err_stuck),
        .err_duty   (err_duty)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_period(input int h, input int l);
        mon_clk = 1'b1;
        wait_cyc(h);
        mon_clk = 1'b0;
        wait_cyc(l);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        wait_cyc(1);
        clr_err = 1'b0;
        wait_cyc(1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_high_len"},  32'(high_len),   0);
        check({tag, "_low_len"},   32'(low_len),    0);
        check({tag, "_period"},    32'(period),     0);
        check({tag, "_meas_valid"}, 32'(meas_valid), 0);
        check({tag, "_locked"},    32'(locked),     0);
        check({tag, "_err_range"}, 32'(err_range),  0);
        check({tag, "_err_stuck"}, 32'(err_stuck),  0);
        check({tag, "_err_duty"},  32'(err_duty),   0);
    endtask

    // Counts period pulses and flags any pulse wider than one cycle.
    always @(negedge clk) begin
        if (meas_valid) begin
            check("mv_width", 32'(mv_prev), 0);
            mv_cnt++;
        end
        mv_prev = meas_valid;
    end

    initial begin
        reset   = 1'b1;
        mon_clk = 1'b0;
        clr_err = 1'b0;
        wait_cyc(3);
        check_zero("rst");
        reset = 1'b0;
        wait_cyc(10);

        // Nominal 10/10 clock: pulses at rises 2..5, lock on the 4th.
        repeat (5) run_period(10, 10);
        check("nom_mv_cnt",   32'(mv_cnt),    4);
        check("nom_locked",   32'(locked),    1);
        check("nom_high_len", 32'(high_len),  10);
        check("nom_low_len",  32'(low_len),   10);
        check("nom_period",   32'(period),    20);
        check("nom_err_rng",  32'(err_range), 0);
        check("nom_err_stk",  32'(err_stuck), 0);

        // Stuck high for 300 cycles: timeout at 256, back to IDLE.
        mon_clk = 1'b1;
        wait_cyc(300);
        check("stk_err",     32'(err_stuck), 1);
        check("stk_locked",  32'(locked),    0);
        check("stk_err_rng", 32'(err_range), 0);
        check("stk_mv_cnt",  32'(mv_cnt),    5);
        mon_clk = 1'b0;
        wait_cyc(10);
        run_period(10, 10);
        check("stk_no_mv",   32'(mv_cnt),    5);
        run_period(10, 10);
        check("stk_mv_2nd",  32'(mv_cnt),    6);
        check("stk_period",  32'(period),    20);
        repeat (2) run_period(10, 10);
        check("stk_relock_3", 32'(locked),   0);
        run_period(10, 10);
        check("stk_relock_4", 32'(locked),   1);

        // Too-fast 2-cycle high phase.
        run_period(2, 10);
        check("fast_high_len", 32'(high_len), 2);
        check("fast_err_rng",  32'(err_range), 1);
        check("fast_locked",   32'(locked),   0);
        run_period(10, 10);
        check("fast_period",   32'(period),   12);
        repeat (3) run_period(10, 10);
        check("fast_relock_3", 32'(locked),   0);
        run_period(10, 10);
        check("fast_relock_4", 32'(locked),   1);

        // Lone clear, then clear racing a fresh range error.
        pulse_clr();
        check("clr_err_rng", 32'(err_range), 0);
        check("clr_err_stk", 32'(err_stuck), 0);
        mon_clk = 1'b1;
        wait_cyc(3);
        mon_clk = 1'b0;
        wait_cyc(2);
        clr_err = 1'b1;
        wait_cyc(1);
        clr_err = 1'b0;
        check("race_err_rng",  32'(err_range), 1);
        check("race_locked",   32'(locked),    0);
        check("race_high_len", 32'(high_len),  3);
        wait_cyc(9);
        pulse_clr();
        check("race_clr_after", 32'(err_range), 0);

        // Range boundaries: 4 and 64 legal, 65 illegal.
        run_period(4, 4);
        check("min_err_rng",  32'(err_range), 0);
        check("min_high_len", 32'(high_len),  4);
        run_period(64, 10);
        check("max_err_rng",  32'(err_range), 0);
        check("max_high_len", 32'(high_len),  64);
        check("min_low_len",  32'(low_len),   4);
        run_period(65, 10);
        check("over_err_rng",  32'(err_range), 1);
        check("over_high_len", 32'(high_len),  65);
        check("over_low_len",  32'(low_len),   10);
        check("over_period",   32'(period),    74);

        // Duty 7/3: flagged only when the duty check is built.
        pulse_clr();
        run_period(7, 3);
        run_period(10, 10);
        check("duty_low_len", 32'(low_len),  3);
        check("duty_err",     32'(err_duty), DUTY_EXP);
        check("duty_period",  32'(period),   10);

        // Reset in the middle of a high phase.
        mon_clk = 1'b1;
        wait_cyc(5);
        #5;
        reset = 1'b1;
        #1;
        check_zero("mid_rst");
        @(negedge clk);
        mon_clk = 1'b0;
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(5);
        mv_snap = mv_cnt;
        run_period(10, 10);
        check("mid_rst_no_mv",   32'(mv_cnt),   mv_snap);
        check("mid_rst_high",    32'(high_len), 10);
        check("mid_rst_period0", 32'(period),   0);
        run_period(10, 10);
        check("mid_rst_mv",      32'(mv_cnt),   mv_snap + 1);
        check("mid_rst_period",  32'(period),   20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
